systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Sequencer for the systolic PE array. It accepts one matrix-tile job through a start/ready handshake and loads weights row by row. It then issues the skewed per-row activation enables and the per-column output-valid strobes that the array's register pipeline requires. It sits between the tile-level scheduler and the array, and replaces hand-inserted delay chains with counter-driven, deterministic enables.

Parameters:
ROWS, 4, number of PE rows (min 1)
COLS, 4, number of PE columns (min 1)
BIT_K, 8, width of the job length field k_len
ROW_SEL_W, $clog2(ROWS) (min 1), width of w_row_sel

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
start  input  1  job request, sampled only when ready=1
k_len  input  BIT_K  activation vectors per job, sampled with start
abort  input  1  synchronous job cancel
ready  output  1  idle and able to accept start
busy  output  1  job in progress, including the done cycle
w_load_en  output  1  weight-load strobe to the array
w_row_sel  output  ROW_SEL_W  row being loaded while w_load_en=1
act_en  output  ROWS  per-row activation enable, skewed
out_valid  output  COLS  per-column result-valid strobe, skewed
done  output  1  one-cycle job-complete pulse

Behaviour:
- All outputs are registered.
- RST=1 forces these values immediately, regardless of CLK: ready=1, every other output 0, state IDLE, all counters and skew registers cleared.
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- busy=1 in every state except IDLE; ready=1 only in IDLE.
- Job acceptance: a job is accepted at edge E0 when start=1, ready=1 and k_len!=0. k_len is latched at E0 as K.
- start with k_len=0 is ignored: the block stays in IDLE and ready stays 1.
- start while busy is ignored.
- Timing below counts cycles after E0, starting at 1.
- LOAD, cycles 1..ROWS: w_load_en=1 and w_row_sel=c-1 in cycle c. Rows are loaded in ascending order.
- STREAM: an internal feed signal is high in cycles ROWS+1..ROWS+K.
- act_en[i] = feed delayed i cycles, i.e. high in cycles ROWS+1+i .. ROWS+K+i.
- out_valid[j] = feed delayed ROWS+j cycles, i.e. high in cycles 2*ROWS+1+j .. 2*ROWS+K+j.
- DRAIN starts after the last feed cycle and ends when out_valid[COLS-1] falls.
- DONE occupies cycle 2*ROWS+K+COLS: done=1 and busy=1 in that cycle.
- ready=1 again in cycle 2*ROWS+K+COLS+1. A start presented in that cycle is accepted.
- Total job latency from E0 to done is 2*ROWS+K+COLS cycles.
- Skew is counter-derived:
  - act_en and out_valid are each a shift-register view of feed.
  - At most one contiguous run of K ones per bit per job.
  - No gaps within a run, no overlap between consecutive jobs.
- Counters:
  - The load counter wraps to 0 after ROWS-1.
  - The stream counter counts K using BIT_K+1-bit arithmetic, so K=2^BIT_K-1 does not overflow.
  - The drain counter is sized for ROWS+COLS.
- Abort:
  - abort=1 at an edge while busy: the next cycle is IDLE with ready=1. All enables and strobes are 0 and the skew registers are cleared; done is not pulsed.
  - abort while IDLE has no effect.
  - abort has priority over start at the same edge.
- RST asserted mid-job behaves as a hard abort. No partial state survives.

Test Plan:
- Basic job: ROWS=COLS=4, start with k_len=3 at E0. Required:
  - w_load_en in cycles 1-4 with w_row_sel 0,1,2,3.
  - act_en[0] in cycles 5-7, act_en[3] in cycles 8-10.
  - out_valid[0] in cycles 9-11, out_valid[3] in cycles 12-14.
  - done in cycle 15 only, ready=1 in cycle 16.
- Minimum job: k_len=1. Required: each act_en/out_valid bit is a single-cycle pulse, and done arrives in cycle 13.
- Rejected starts:
  - start with k_len=0 -> ready stays 1 and all outputs stay 0.
  - start pulsed in cycle 6 of a job -> ignored; the original job's timing is unchanged.
- Back-to-back jobs: second start held high through cycle 16 -> accepted at the end of cycle 16; its w_load_en begins in cycle 17. No overlap of out_valid between the two jobs.
- Abort: abort=1 in cycle 7 with k_len=3 -> cycle 8 has ready=1 and act_en=0, out_valid=0, w_load_en=0; done never asserts. A fresh job afterwards shows nominal timing.
- Reset mid-job: RST asserted asynchronously (between CLK edges) in cycle 10 of a k_len=255 job. Required:
  - All outputs go to reset values without a clock edge; ready=1.
  - After RST is released, k_len=255 runs to done in cycle 2*4+255+4=267.

Source files
------------

// File: rtl/systolic_seq_ctrl_if.sv
// Job handshake and array-control bundle between the tile scheduler (master)
// and the systolic sequencer (slave).
interface systolic_seq_ctrl_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int BIT_K = 8
);
    localparam int ROW_SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 start;
    logic [BIT_K-1:0]     k_len;
    logic                 abort;
    logic                 ready;
    logic                 busy;
    logic                 w_load_en;
    logic [ROW_SEL_W-1:0] w_row_sel;
    logic [ROWS-1:0]      act_en;
    logic [COLS-1:0]      out_valid;
    logic                 done;

    modport master (
        output start, k_len, abort,
        input  ready, busy, w_load_en, w_row_sel, act_en, out_valid, done
    );

    modport slave (
        input  start, k_len, abort,
        output ready, busy, w_load_en, w_row_sel, act_en, out_valid, done
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Counter-driven sequencer for the systolic PE array: weight load, skewed
// activation enables and skewed per-column output-valid strobes for one job.
module systolic_seq_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int BIT_K = 8
) (
    input  logic               CLK,
    input  logic               RST,
    systolic_seq_ctrl_if.slave bus
);
    localparam int ROW_SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN_LEN = ROWS + COLS - 1;
    localparam int DRAIN_W   = $clog2(ROWS + COLS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [ROW_SEL_W-1:0] r_load_cnt, w_load_cnt_nxt;
    logic [BIT_K:0]       r_stream_cnt, w_stream_cnt_nxt;
    logic [DRAIN_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
    logic [BIT_K-1:0]     r_k, w_k_nxt;

    logic                 r_ready, r_busy, r_load_en, r_done;
    logic [ROWS-1:0]      r_act_en;
    logic [COLS-1:0]      r_out_valid;
    logic                 w_ready_nxt, w_busy_nxt, w_load_en_nxt, w_done_nxt, w_feed_nxt;
    logic [ROWS-1:0]      w_act_en_nxt;
    logic [COLS-1:0]      w_out_valid_nxt;
    logic                 w_abort;

    assign w_abort = bus.abort && (r_state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_load_cnt   <= '0;
            r_stream_cnt <= '0;
            r_drain_cnt  <= '0;
            r_k          <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_load_en    <= 1'b0;
            r_done       <= 1'b0;
            r_act_en     <= '0;
            r_out_valid  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_cnt   <= w_load_cnt_nxt;
            r_stream_cnt <= w_stream_cnt_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_k          <= w_k_nxt;
            r_ready      <= w_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_load_en    <= w_load_en_nxt;
            r_done       <= w_done_nxt;
            r_act_en     <= w_act_en_nxt;
            r_out_valid  <= w_out_valid_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_cnt_nxt   = '0;
        w_stream_cnt_nxt = '0;
        w_drain_cnt_nxt  = '0;
        w_k_nxt          = r_k;
        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.k_len != '0)) begin
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = bus.k_len;
                end
            end
            S_LOAD: begin
                if (r_load_cnt == ROW_SEL_W'(ROWS - 1)) begin
                    w_state_nxt      = S_STREAM;
                    w_stream_cnt_nxt = (BIT_K + 1)'(1);
                end else begin
                    w_load_cnt_nxt = r_load_cnt + 1'b1;
                end
            end
            S_STREAM: begin
                if (r_stream_cnt == {1'b0, r_k}) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = DRAIN_W'(1);
                end else begin
                    w_stream_cnt_nxt = r_stream_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // Drain lasts until the last column's strobe has fallen.
                if (r_drain_cnt == DRAIN_W'(DRAIN_LEN)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt      = S_IDLE;
            w_load_cnt_nxt   = '0;
            w_stream_cnt_nxt = '0;
            w_drain_cnt_nxt  = '0;
        end
    end

    // Outputs are decoded from the next state so they are registered yet aligned.
    always_comb begin
        w_ready_nxt   = (w_state_nxt == S_IDLE);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_load_en_nxt = (w_state_nxt == S_LOAD);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_feed_nxt    = (w_state_nxt == S_STREAM);
        if (w_abort) begin
            w_act_en_nxt    = '0;
            w_out_valid_nxt = '0;
        end else begin
            w_act_en_nxt    = (r_act_en << 1) | ROWS'(w_feed_nxt);
            w_out_valid_nxt = (r_out_valid << 1) | COLS'(r_act_en[ROWS-1]);
        end
    end

    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.w_load_en = r_load_en;
    assign bus.w_row_sel = r_load_cnt;
    assign bus.act_en    = r_act_en;
    assign bus.out_valid = r_out_valid;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-offset model of the job timeline.
module tb_systolic_seq_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int BIT_K = 8;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       w_load_en;
        logic [1:0] row_sel;
        logic [3:0] act_en;
        logic [3:0] out_valid;
        logic       done;
    } outs_t;

    logic CLK;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: whether a job is live, which cycle after acceptance we are in, and K.
    bit   m_active = 1'b0;
    int   m_c      = 0;
    int   m_k      = 0;

    systolic_seq_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .BIT_K(BIT_K)) bus ();
    systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .BIT_K(BIT_K)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic outs_t model_out();
        outs_t o;
        o = '0;
        if (!m_active) begin
            o.ready = 1'b1;
            return o;
        end
        o.busy      = 1'b1;
        o.w_load_en = (m_c <= ROWS);
        if (m_c <= ROWS) o.row_sel = 2'(m_c - 1);
        for (int i = 0; i < ROWS; i++)
            o.act_en[i] = (m_c >= ROWS + 1 + i) && (m_c <= ROWS + m_k + i);
        for (int j = 0; j < COLS; j++)
            o.out_valid[j] = (m_c >= 2 * ROWS + 1 + j) && (m_c <= 2 * ROWS + m_k + j);
        o.done = (m_c == 2 * ROWS + m_k + COLS);
        return o;
    endfunction

    function automatic void model_step(input logic s, input int k, input logic a);
        if (m_active) begin
            if (a || (m_c == 2 * ROWS + m_k + COLS)) m_active = 1'b0;
            else m_c++;
        end else if (s && (k != 0)) begin
            m_active = 1'b1;
            m_c      = 1;
            m_k      = k;
        end
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.ready     = bus.ready;
        o.busy      = bus.busy;
        o.w_load_en = bus.w_load_en;
        o.row_sel   = bus.w_load_en ? bus.w_row_sel : 2'b0;
        o.act_en    = bus.act_en;
        o.out_valid = bus.out_valid;
        o.done      = bus.done;
        return o;
    endfunction

    task automatic drive_cycle(input logic s, input int k, input logic a);
        bus.start = s;
        bus.k_len = 8'(k);
        bus.abort = a;
        @(posedge CLK);
        model_step(s, k, a);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        outs_t obs, exp;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.abort = 1'b0;
        RST = 1'b0;
        #1 RST = 1'b1;
        #2;
        m_active = 1'b0;
        obs = dut_outs(); exp = model_out(); n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL reset_async got %b want %b", obs, exp);
        end
        repeat (2) @(negedge CLK);
        obs = dut_outs(); n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL reset_held got %b want %b", obs, exp);
        end
        RST = 1'b0;
        drive_cycle(1'b0, 0, 1'b0);
        obs = dut_outs(); exp = model_out(); n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL reset_release got %b want %b", obs, exp);
        end
    endtask

    task automatic test_basic();
        outs_t obs, exp;
        int done_c = 0;
        drive_cycle(1'b1, 3, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL basic c=%0d got %b want %b", c, obs, exp);
            end
            if (obs.done && done_c == 0) done_c = c;
            if (c < 16) drive_cycle(1'b0, 0, 1'b0);
        end
        n_checks++;
        if (done_c != 15) begin
            n_errors++;
            $display("FAIL basic_done_cycle got %0d want 15", done_c);
        end
    endtask

    task automatic test_min_job();
        outs_t obs, exp;
        int done_c = 0;
        int act_cnt[ROWS];
        int ov_cnt[COLS];
        for (int i = 0; i < ROWS; i++) act_cnt[i] = 0;
        for (int j = 0; j < COLS; j++) ov_cnt[j] = 0;
        drive_cycle(1'b1, 1, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL min_job c=%0d got %b want %b", c, obs, exp);
            end
            for (int i = 0; i < ROWS; i++) act_cnt[i] += int'(obs.act_en[i]);
            for (int j = 0; j < COLS; j++) ov_cnt[j] += int'(obs.out_valid[j]);
            if (obs.done && done_c == 0) done_c = c;
            if (c < 14) drive_cycle(1'b0, 0, 1'b0);
        end
        n_checks++;
        if (done_c != 13) begin
            n_errors++;
            $display("FAIL min_job_done_cycle got %0d want 13", done_c);
        end
        for (int i = 0; i < ROWS; i++) begin
            n_checks++;
            if (act_cnt[i] != 1 || ov_cnt[i] != 1) begin
                n_errors++;
                $display("FAIL min_job_pulse bit=%0d got act=%0d ov=%0d want 1", i, act_cnt[i], ov_cnt[i]);
            end
        end
    endtask

    task automatic test_rejected();
        outs_t obs, exp;
        int done_c = 0;
        for (int n = 0; n < 4; n++) begin
            drive_cycle(1'b1, 0, 1'b0);
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL reject_k0 n=%0d got %b want %b", n, obs, exp);
            end
        end
        drive_cycle(1'b1, 3, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL reject_busy c=%0d got %b want %b", c, obs, exp);
            end
            if (obs.done && done_c == 0) done_c = c;
            if (c < 16) drive_cycle(c == 6, 5, 1'b0);
        end
        n_checks++;
        if (done_c != 15) begin
            n_errors++;
            $display("FAIL reject_busy_done_cycle got %0d want 15", done_c);
        end
    endtask

    task automatic test_back_to_back();
        outs_t obs, exp;
        int k2;
        int last_c;
        int load2_c = 0;
        k2     = $urandom_range(1, 6);
        last_c = 16 + 2 * ROWS + k2 + COLS + 1;
        drive_cycle(1'b1, 3, 1'b0);
        for (int c = 1; c <= last_c; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL b2b c=%0d got %b want %b", c, obs, exp);
            end
            if (obs.w_load_en && c > ROWS && load2_c == 0) load2_c = c;
            if (c < last_c) drive_cycle(c >= 10 && c <= 16, k2, 1'b0);
        end
        n_checks++;
        if (load2_c != 17) begin
            n_errors++;
            $display("FAIL b2b_second_load got %0d want 17", load2_c);
        end
    endtask

    task automatic test_abort();
        outs_t obs, exp;
        bit done_seen = 1'b0;
        int done_c    = 0;
        drive_cycle(1'b1, 3, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL abort c=%0d got %b want %b", c, obs, exp);
            end
            if (obs.done) done_seen = 1'b1;
            if (c == 8) begin
                n_checks++;
                if (!(obs.ready && !obs.busy && !obs.w_load_en && obs.act_en == 0 && obs.out_valid == 0)) begin
                    n_errors++;
                    $display("FAIL abort_idle got %b want ready only", obs);
                end
            end
            drive_cycle(1'b0, 0, c == 7);
        end
        n_checks++;
        if (done_seen) begin
            n_errors++;
            $display("FAIL abort_no_done got 1 want 0");
        end
        drive_cycle(1'b1, 3, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL abort_fresh c=%0d got %b want %b", c, obs, exp);
            end
            if (obs.done && done_c == 0) done_c = c;
            if (c < 16) drive_cycle(1'b0, 0, 1'b0);
        end
        n_checks++;
        if (done_c != 15) begin
            n_errors++;
            $display("FAIL abort_fresh_done_cycle got %0d want 15", done_c);
        end
    endtask

    task automatic test_reset_mid_job();
        outs_t obs, exp;
        int done_c = 0;
        drive_cycle(1'b1, 255, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL midrst_pre c=%0d got %b want %b", c, obs, exp);
            end
            if (c < 10) drive_cycle(1'b0, 0, 1'b0);
        end
        // Assert reset between edges and observe before the next rising edge.
        #2 RST = 1'b1;
        #1;
        m_active = 1'b0;
        obs = dut_outs(); exp = model_out(); n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL midrst_async got %b want %b", obs, exp);
        end
        @(negedge CLK);
        RST = 1'b0;
        drive_cycle(1'b1, 255, 1'b0);
        for (int c = 1; c <= 268; c++) begin
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL midrst_rerun c=%0d got %b want %b", c, obs, exp);
            end
            if (obs.done && done_c == 0) done_c = c;
            if (c < 268) drive_cycle(1'b0, 0, 1'b0);
        end
        n_checks++;
        if (done_c != 267) begin
            n_errors++;
            $display("FAIL midrst_done_cycle got %0d want 267", done_c);
        end
    endtask

    task automatic test_random();
        outs_t obs, exp;
        logic  s, a;
        int    k;
        for (int n = 0; n < 1500; n++) begin
            s = ($urandom_range(0, 3) == 0);
            k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            a = m_active && ($urandom_range(0, 39) == 0);
            drive_cycle(s, k, a);
            obs = dut_outs(); exp = model_out(); n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL random n=%0d got %b want %b", n, obs, exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_min_job();
        test_rejected();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
